// File: rtl/whack_datapath.sv
// Datapath partner of the whack-a-mole game FSM: mole spawn/lifetime sequencing,
// synchronised button edge detection, game timer and saturating score/miss counters.
module whack_datapath #(
    parameter int unsigned GAME_CYCLES  = 1500000000,
    parameter int unsigned SPAWN_CYCLES = 25000000,
    parameter int unsigned MOLE_CYCLES  = 50000000,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         state,
    input  logic               game_start,
    input  logic [3:0]         hit,
    output logic               control_signal,
    output logic               timer_signal,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic [2:0]         seq_state
);

    localparam int GW = (GAME_CYCLES > 1) ? $clog2(GAME_CYCLES) : 1;
    localparam int SW = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
    localparam int LW = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
    localparam logic [SCORE_W-1:0] COUNT_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        SEQ_IDLE        = 3'd0,
        SEQ_SPAWN_WAIT  = 3'd1,
        SEQ_REQ_WAIT    = 3'd2,
        SEQ_MOLE_ACTIVE = 3'd3,
        SEQ_ACK_WAIT    = 3'd4,
        SEQ_DONE        = 3'd5
    } seq_t;

    seq_t seq_q, seq_d;

    logic [3:0]    sync1, sync2, sync3, rise_q;
    logic [GW-1:0] game_cnt;
    logic [SW-1:0] spawn_cnt;
    logic [LW-1:0] life_cnt;
    logic [1:0]    mole_k;

    logic st_game, st_mole, st_over, st_start, st_play;
    logic counting, expired, frozen, clear_game;
    logic hit_k, hit_wrong, spawn_done, life_done;
    logic pulse, score_inc, miss_inc;
    logic [3:0] mole_mask;

    assign seq_state = seq_q;

    // Any code outside 0..6 falls through to Start.
    assign st_game  = (state == 4'd1);
    assign st_mole  = (state >= 4'd2) && (state <= 4'd5);
    assign st_over  = (state == 4'd6);
    assign st_start = !(st_game || st_mole || st_over);
    assign st_play  = st_game || st_mole;

    assign counting   = (seq_q != SEQ_IDLE) && st_play;
    assign expired    = counting && (game_cnt == '0);
    assign frozen     = timer_signal || expired;
    assign clear_game = (seq_q == SEQ_IDLE) && game_start;

    assign mole_mask  = 4'b0001 << mole_k;
    assign hit_k      = |(rise_q & mole_mask);
    assign hit_wrong  = |(rise_q & ~mole_mask);
    assign spawn_done = (spawn_cnt == SW'(SPAWN_CYCLES - 1));
    assign life_done  = (life_cnt == LW'(MOLE_CYCLES - 1));

    // Handshake with the game FSM: each control_signal pulse is answered by a state change
    // (Game -> MoleN or MoleN -> Game) some cycles later; REQ_WAIT and ACK_WAIT block any
    // further pulse until that answer is seen, so FSM lag can never produce a double step.
    always_comb begin
        seq_d     = seq_q;
        pulse     = 1'b0;
        score_inc = 1'b0;
        miss_inc  = 1'b0;
        case (seq_q)
            SEQ_IDLE: begin
                if (st_game) seq_d = SEQ_SPAWN_WAIT;
            end
            SEQ_SPAWN_WAIT: begin
                if (spawn_done && !frozen) begin
                    pulse = 1'b1;
                    seq_d = SEQ_REQ_WAIT;
                end
            end
            SEQ_REQ_WAIT: begin
                if (st_mole) seq_d = SEQ_MOLE_ACTIVE;
            end
            SEQ_MOLE_ACTIVE: begin
                // A correct press beats both a simultaneous wrong press and lifetime expiry.
                if (!frozen) begin
                    if (hit_k) begin
                        score_inc = 1'b1;
                        pulse     = 1'b1;
                        seq_d     = SEQ_ACK_WAIT;
                    end else if (life_done) begin
                        miss_inc = 1'b1;
                        pulse    = 1'b1;
                        seq_d    = SEQ_ACK_WAIT;
                    end else if (hit_wrong) begin
                        miss_inc = 1'b1;
                    end
                end
            end
            SEQ_ACK_WAIT: begin
                if (st_game) seq_d = SEQ_SPAWN_WAIT;
            end
            SEQ_DONE: begin
                seq_d = SEQ_DONE;
            end
            default: begin
                seq_d = SEQ_IDLE;
            end
        endcase
        if (st_over || st_start) begin
            seq_d     = st_over ? SEQ_DONE : SEQ_IDLE;
            pulse     = 1'b0;
            score_inc = 1'b0;
            miss_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q <= SEQ_IDLE;
        end else begin
            seq_q <= seq_d;
        end
    end

    // Two-flop synchroniser, a third flop for edge detection, then a registered edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            rise_q <= '0;
        end else begin
            sync1  <= hit;
            sync2  <= sync1;
            sync3  <= sync2;
            rise_q <= sync2 & ~sync3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spawn_cnt <= '0;
            life_cnt  <= '0;
            mole_k    <= '0;
        end else begin
            if (seq_q != SEQ_SPAWN_WAIT) begin
                spawn_cnt <= '0;
            end else if (!spawn_done) begin
                spawn_cnt <= spawn_cnt + 1'b1;
            end
            if (seq_q != SEQ_MOLE_ACTIVE) begin
                life_cnt <= '0;
            end else if (!life_done) begin
                life_cnt <= life_cnt + 1'b1;
            end
            if ((seq_q == SEQ_REQ_WAIT) && st_mole) begin
                mole_k <= 2'(state - 4'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            game_cnt     <= '0;
            timer_signal <= 1'b0;
        end else if (clear_game) begin
            game_cnt     <= GW'(GAME_CYCLES - 1);
            timer_signal <= 1'b0;
        end else begin
            if (counting && (game_cnt != '0)) begin
                game_cnt <= game_cnt - 1'b1;
            end
            if (expired) begin
                timer_signal <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score          <= '0;
            misses         <= '0;
            control_signal <= 1'b0;
        end else begin
            control_signal <= pulse;
            if (clear_game) begin
                score  <= '0;
                misses <= '0;
            end else begin
                if (score_inc && (score != COUNT_MAX)) score <= score + 1'b1;
                if (miss_inc && (misses != COUNT_MAX)) misses <= misses + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_whack_datapath.sv
// Bench for whack_datapath: a lagging game-FSM model drives state, scenario tasks check
// spawn/hit/miss/timer timing and counts against expectations derived from the game rules.
module tb_whack_datapath;

    localparam int G      = 200;
    localparam int G_LONG = 1000;
    localparam int S      = 10;
    localparam int M      = 20;
    localparam int W      = 4;
    localparam logic [3:0] ST_START = 4'd0;
    localparam logic [3:0] ST_GAME  = 4'd1;
    localparam logic [3:0] ST_OVER  = 4'd6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   state = 4'd0;
    logic         game_start = 1'b0;
    logic [3:0]   hit = 4'd0;
    logic         cs_a, tm_a, cs_b, tm_b;
    logic [W-1:0] sc_a, ms_a, sc_b, ms_b;
    logic [2:0]   sq_a, sq_b;

    // Observed values of the selected instance, sampled on the falling edge.
    logic         cs, tm, seen, l1, l2;
    logic [W-1:0] sc, ms;
    bit           sel_long = 0;
    bit           auto_fsm = 0;
    int           force_mole = -1;
    int           pulses = 0;
    int           cyc = 0;
    int           game_edge = 0;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_score, exp_miss;

    whack_datapath #(.GAME_CYCLES(G), .SPAWN_CYCLES(S), .MOLE_CYCLES(M), .SCORE_W(W)) dut (
        .clk(clk), .reset(reset), .state(state), .game_start(game_start), .hit(hit),
        .control_signal(cs_a), .timer_signal(tm_a), .score(sc_a), .misses(ms_a),
        .seq_state(sq_a)
    );

    whack_datapath #(.GAME_CYCLES(G_LONG), .SPAWN_CYCLES(S), .MOLE_CYCLES(M), .SCORE_W(W)) dut_long (
        .clk(clk), .reset(reset), .state(state), .game_start(game_start), .hit(hit),
        .control_signal(cs_b), .timer_signal(tm_b), .score(sc_b), .misses(ms_b),
        .seq_state(sq_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: sim time exhausted, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == {W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // One clock: sample outputs, then let the game-FSM model react to pulses seen 2 cycles ago.
    task automatic cycle();
        int m;
        @(negedge clk);
        cs = sel_long ? cs_b : cs_a;
        tm = sel_long ? tm_b : tm_a;
        sc = sel_long ? sc_b : sc_a;
        ms = sel_long ? ms_b : ms_a;
        if (cs === 1'b1) pulses++;
        seen = l2;
        l2 = l1;
        l1 = cs;
        if (auto_fsm) begin
            if (tm === 1'b1) begin
                state = ST_OVER;
            end else if (seen === 1'b1) begin
                if (state == ST_GAME) begin
                    m = (force_mole >= 0) ? force_mole : int'($urandom_range(0, 3));
                    state = 4'(2 + m);
                end else if (state >= 4'd2 && state <= 4'd5) begin
                    state = ST_GAME;
                end
            end
        end
    endtask

    task automatic wait_pulse(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            cycle();
            if (cs === 1'b1) at = cyc;
        end
    endtask

    task automatic wait_mole(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            if (state >= 4'd2 && state <= 4'd5) begin
                cycle();
                at = cyc;
            end else begin
                cycle();
            end
        end
    endtask

    task automatic start_game();
        auto_fsm = 0;
        l1 = 1'b0;
        l2 = 1'b0;
        hit = 4'd0;
        state = ST_START;
        game_start = 1'b1;
        cycle();
        cycle();
        game_start = 1'b0;
        state = ST_GAME;
        cycle();
        game_edge = cyc;
        auto_fsm = 1;
        exp_score = '0;
        exp_miss = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        cycle();
        total++; if (cs_a !== 1'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", cs_a); end
        total++; if (tm_a !== 1'b0) begin bad++; $display("FAIL reset_timer: got %b want 0", tm_a); end
        total++; if (sc_a !== '0) begin bad++; $display("FAIL reset_score: got %0d want 0", sc_a); end
        total++; if (ms_a !== '0) begin bad++; $display("FAIL reset_misses: got %0d want 0", ms_a); end
        total++; if (sc_b !== '0 || ms_b !== '0) begin bad++; $display("FAIL reset_long: got %0d/%0d want 0/0", sc_b, ms_b); end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_spawn_hit();
        int p, p2, e, n;
        sel_long = 0;
        force_mole = 1;
        start_game();
        wait_pulse(S + 5, p);
        total++; if (p != game_edge + S) begin bad++; $display("FAIL spawn_time: got %0d want %0d", p, game_edge + S); end
        cycle();
        total++; if (cs !== 1'b0) begin bad++; $display("FAIL spawn_width: got %b want 0", cs); end
        wait_mole(10, e);
        total++; if (e < 0 || state != 4'd3) begin bad++; $display("FAIL mole2_entry: got state %0d want 3", state); end
        hit = 4'b0010;
        cycle();
        n = cyc;
        wait_pulse(6, p);
        exp_score = sat_inc(exp_score);
        total++; if (p != n + 3) begin bad++; $display("FAIL hit_latency: got %0d want %0d", p, n + 3); end
        total++; if (sc !== exp_score) begin bad++; $display("FAIL hit_score: got %0d want %0d", sc, exp_score); end
        hit = 4'd0;
        cycle();
        total++; if (cs !== 1'b0) begin bad++; $display("FAIL hit_width: got %b want 0", cs); end
        wait_pulse(S + 8, p2);
        total++; if (p2 != p + 3 + S) begin bad++; $display("FAIL ack_respawn: got %0d want %0d", p2, p + 3 + S); end
    endtask

    task automatic test_wrong_and_timeout();
        int p, e, n, wb, d, pb;
        sel_long = 0;
        force_mole = 2;
        start_game();
        wait_pulse(S + 5, p);
        wait_mole(10, e);
        do wb = $urandom_range(0, 3); while (wb == 2);
        d = $urandom_range(0, 4);
        for (int i = 0; i < d; i++) cycle();
        pb = pulses;
        hit = 4'd1 << wb;
        cycle();
        n = cyc;
        cycle();
        cycle();
        total++; if (ms !== exp_miss) begin bad++; $display("FAIL wrong_early: got %0d want %0d", ms, exp_miss); end
        cycle();
        exp_miss = sat_inc(exp_miss);
        total++; if (ms !== exp_miss) begin bad++; $display("FAIL wrong_miss: got %0d want %0d", ms, exp_miss); end
        total++; if (pulses != pb) begin bad++; $display("FAIL wrong_no_pulse: got %0d want %0d", pulses - pb, 0); end
        hit = 4'd0;
        wait_pulse(M + 5, p);
        exp_miss = sat_inc(exp_miss);
        total++; if (p != e + M) begin bad++; $display("FAIL timeout_time: got %0d want %0d", p, e + M); end
        total++; if (ms !== exp_miss || sc !== exp_score) begin
            bad++; $display("FAIL timeout_counts: got %0d/%0d want %0d/%0d", sc, ms, exp_score, exp_miss);
        end
    endtask

    task automatic test_tie();
        int p, p2, e;
        logic [3:0] extra;
        sel_long = 0;
        force_mole = 2;
        start_game();
        wait_pulse(S + 5, p);
        wait_mole(10, e);
        extra = 4'($urandom_range(0, 15)) & 4'b1011;
        while (cyc < e + M - 4) cycle();
        hit = 4'b0100 | extra;
        cycle();
        wait_pulse(6, p);
        exp_score = sat_inc(exp_score);
        total++; if (p != e + M) begin bad++; $display("FAIL tie_time: got %0d want %0d", p, e + M); end
        total++; if (sc !== exp_score || ms !== exp_miss) begin
            bad++; $display("FAIL tie_counts: got %0d/%0d want %0d/%0d", sc, ms, exp_score, exp_miss);
        end
        hit = 4'd0;
        wait_pulse(S + 8, p2);
        total++; if (p2 != p + 3 + S) begin bad++; $display("FAIL tie_single_pulse: got %0d want %0d", p2, p + 3 + S); end
    endtask

    task automatic test_async_reset();
        int p, e, k;
        sel_long = 0;
        force_mole = -1;
        start_game();
        for (int r = 0; r < 3; r++) begin
            wait_pulse(S + 8, p);
            wait_mole(10, e);
            k = int'(state) - 2;
            hit = 4'd1 << k;
            cycle();
            wait_pulse(6, p);
            hit = 4'd0;
            exp_score = sat_inc(exp_score);
        end
        wait_pulse(S + 8, p);
        wait_mole(10, e);
        cycle();
        total++; if (sc !== exp_score) begin bad++; $display("FAIL pre_reset_score: got %0d want %0d", sc, exp_score); end
        #2 reset = 1'b0;
        #1;
        total++; if (sc_a !== '0 || ms_a !== '0) begin bad++; $display("FAIL async_reset_counts: got %0d/%0d want 0/0", sc_a, ms_a); end
        total++; if (cs_a !== 1'b0 || tm_a !== 1'b0) begin bad++; $display("FAIL async_reset_flags: got %b%b want 00", cs_a, tm_a); end
        auto_fsm = 0;
        state = ST_START;
        cycle();
        cycle();
        reset = 1'b1;
        start_game();
        wait_pulse(S + 5, p);
        total++; if (p != game_edge + S) begin bad++; $display("FAIL post_reset_spawn: got %0d want %0d", p, game_edge + S); end
    endtask

    task automatic test_hold_abort();
        int p, e, n, kk, pb;
        sel_long = 0;
        kk = $urandom_range(0, 3);
        force_mole = kk;
        start_game();
        wait_pulse(S + 5, p);
        wait_mole(10, e);
        hit = 4'd1 << kk;
        cycle();
        n = cyc;
        wait_pulse(6, p);
        exp_score = sat_inc(exp_score);
        total++; if (p != n + 3 || sc !== exp_score) begin bad++; $display("FAIL hold_first: got %0d@%0d want %0d@%0d", sc, p, exp_score, n + 3); end
        wait_pulse(S + 8, p);
        wait_mole(10, e);
        wait_pulse(M + 5, p);
        exp_miss = sat_inc(exp_miss);
        total++; if (p != e + M) begin bad++; $display("FAIL hold_timeout_time: got %0d want %0d", p, e + M); end
        total++; if (sc !== exp_score || ms !== exp_miss) begin
            bad++; $display("FAIL hold_counted_once: got %0d/%0d want %0d/%0d", sc, ms, exp_score, exp_miss);
        end
        while (cyc < n + 49) cycle();
        hit = 4'd0;
        wait_pulse(S + 8, p);
        wait_mole(10, e);
        hit = 4'd1 << kk;
        cycle();
        n = cyc;
        wait_pulse(6, p);
        exp_score = sat_inc(exp_score);
        total++; if (p != n + 3 || sc !== exp_score) begin bad++; $display("FAIL repress: got %0d@%0d want %0d@%0d", sc, p, exp_score, n + 3); end
        hit = 4'd0;
        auto_fsm = 0;
        state = ST_START;
        pb = pulses;
        for (int i = 0; i < 30; i++) cycle();
        total++; if (pulses != pb) begin bad++; $display("FAIL abort_no_pulse: got %0d want 0", pulses - pb); end
        total++; if (sc !== exp_score || ms !== exp_miss) begin
            bad++; $display("FAIL abort_hold: got %0d/%0d want %0d/%0d", sc, ms, exp_score, exp_miss);
        end
        l1 = 1'b0;
        l2 = 1'b0;
        state = ST_GAME;
        cycle();
        e = cyc;
        auto_fsm = 1;
        wait_pulse(S + 5, p);
        total++; if (p != e + S) begin bad++; $display("FAIL resume_spawn: got %0d want %0d", p, e + S); end
    endtask

    task automatic test_timer();
        int t_at, pb;
        logic cs_t;
        logic [W-1:0] sc_t, ms_t;
        sel_long = 0;
        force_mole = -1;
        start_game();
        t_at = -1;
        for (int i = 0; i < G + 40 && t_at < 0; i++) begin
            if (state >= 4'd2 && state <= 4'd5 && hit == 4'd0 && $urandom_range(0, 5) == 0)
                hit = 4'd1 << (state - 4'd2);
            else
                hit = 4'd0;
            cycle();
            if (tm === 1'b1) t_at = cyc;
        end
        cs_t = cs;
        sc_t = sc;
        ms_t = ms;
        total++; if (t_at != game_edge + G) begin bad++; $display("FAIL timer_time: got %0d want %0d", t_at, game_edge + G); end
        total++; if (cs_t !== 1'b0) begin bad++; $display("FAIL timer_edge_pulse: got %b want 0", cs_t); end
        pb = pulses;
        for (int i = 0; i < 30; i++) begin
            hit = 4'($urandom_range(0, 15));
            cycle();
        end
        hit = 4'd0;
        total++; if (pulses != pb) begin bad++; $display("FAIL timer_no_pulse: got %0d want 0", pulses - pb); end
        total++; if (sc !== sc_t || ms !== ms_t || tm !== 1'b1) begin
            bad++; $display("FAIL timer_freeze: got %0d/%0d/%b want %0d/%0d/1", sc, ms, tm, sc_t, ms_t);
        end
        auto_fsm = 0;
        state = ST_START;
        game_start = 1'b1;
        cycle();
        cycle();
        cycle();
        game_start = 1'b0;
        total++; if (tm !== 1'b0 || sc !== '0 || ms !== '0) begin
            bad++; $display("FAIL start_clears: got %b/%0d/%0d want 0/0/0", tm, sc, ms);
        end
    endtask

    task automatic test_saturate();
        int p, e, k;
        sel_long = 1;
        force_mole = -1;
        start_game();
        for (int r = 0; r < 17; r++) begin
            wait_pulse(S + 8, p);
            wait_mole(10, e);
            k = int'(state) - 2;
            hit = 4'd1 << k;
            cycle();
            wait_pulse(6, p);
            hit = 4'd0;
            exp_score = sat_inc(exp_score);
            total++; if (sc !== exp_score) begin bad++; $display("FAIL sat_round%0d: got %0d want %0d", r, sc, exp_score); end
        end
        total++; if (sc !== 4'd15 || ms !== exp_miss) begin bad++; $display("FAIL sat_final: got %0d/%0d want 15/%0d", sc, ms, exp_miss); end
        auto_fsm = 0;
        state = ST_START;
        sel_long = 0;
        cycle();
    endtask

    initial begin
        l1 = 1'b0;
        l2 = 1'b0;
        exp_score = '0;
        exp_miss = '0;
        test_reset();
        test_spawn_hit();
        test_wrong_and_timeout();
        test_tie();
        test_async_reset();
        test_hold_abort();
        test_timer();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
